// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and limits for the Gray counter family.
// Values are zero-extended to GRAY_MAX_WIDTH, so one conversion serves every legal width.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 16;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Leading zeros from zero-extension leave the prefix-XOR of the live bits unchanged.
  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: bit i is the XOR of gray_i[WIDTH-1:i].
// Zero latency, no flow control.
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_prefix
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down Gray counter with parallel Gray load, wrap/saturate boundary mode,
// sticky overflow/underflow flags and a registered one-cycle boundary pulse.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadGray,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_bin;

  gray2bin #(.WIDTH(WIDTH)) u_load_conv (
    .gray_i (LoadGray),
    .bin_o  (load_bin)
  );

  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = ovf_q & ~ClrFlags;
    unf_d  = unf_q & ~ClrFlags;
    wrap_d = 1'b0;
    if (Load) begin
      cnt_d = load_bin;
    end else if (En) begin
      if (Up) begin
        if (cnt_q == CNT_MAX) begin
          // A set in the same cycle as ClrFlags must win, so it comes last.
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
          cnt_d  = SATURATE ? cnt_q : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          wrap_d = 1'b1;
          unf_d  = 1'b1;
          cnt_d  = SATURATE ? cnt_q : CNT_MAX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      wrap_q <= wrap_d;
    end
  end

  assign Binary    = cnt_q;
  assign Output    = WIDTH'(bin2gray(gray_word_t'(cnt_q)));
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: three configurations (W3 wrap, W4 wrap, W4 saturate)
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_gray = '0;
  logic       clr = 1'b0;

  logic [2:0] g3, b3;
  logic [3:0] g4w, b4w, g4s, b4s;
  logic       ovf[3], unf[3], wrp[3];
  logic [3:0] out_g[3], out_b[3];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, plain integers.
  int  width[3] = '{3, 4, 4};
  bit  sat[3]   = '{1'b0, 1'b0, 1'b1};
  int  m_cnt[3];
  bit  m_ovf[3], m_unf[3], m_wrap[3];

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(3), .SATURATE(1'b0)) dut_w3 (
    .Clk(clk), .Reset(reset), .En(en), .Up(up), .Load(load), .LoadGray(load_gray[2:0]),
    .ClrFlags(clr), .Output(g3), .Binary(b3), .Overflow(ovf[0]), .Underflow(unf[0]), .Wrap(wrp[0]));

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) dut_w4 (
    .Clk(clk), .Reset(reset), .En(en), .Up(up), .Load(load), .LoadGray(load_gray),
    .ClrFlags(clr), .Output(g4w), .Binary(b4w), .Overflow(ovf[1]), .Underflow(unf[1]), .Wrap(wrp[1]));

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) dut_s4 (
    .Clk(clk), .Reset(reset), .En(en), .Up(up), .Load(load), .LoadGray(load_gray),
    .ClrFlags(clr), .Output(g4s), .Binary(b4s), .Overflow(ovf[2]), .Underflow(unf[2]), .Wrap(wrp[2]));

  assign out_g[0] = {1'b0, g3};
  assign out_b[0] = {1'b0, b3};
  assign out_g[1] = g4w;
  assign out_b[1] = b4w;
  assign out_g[2] = g4s;
  assign out_b[2] = b4s;

  function automatic int to_gray(input int n);
    return n ^ (n >> 1);
  endfunction

  // Search the code space for the value whose Gray code matches.
  function automatic int from_gray(input int g, input int w);
    for (int n = 0; n < (1 << w); n++) begin
      if (to_gray(n) == g) return n;
    end
    return -1;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int top;
      top = (1 << width[k]) - 1;
      if (reset) begin
        m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_wrap[k] = 0;
      end else begin
        m_wrap[k] = 0;
        if (clr) begin
          m_ovf[k] = 0; m_unf[k] = 0;
        end
        if (load) begin
          m_cnt[k] = from_gray(int'(load_gray) & top, width[k]);
        end else if (en && up) begin
          if (m_cnt[k] == top) begin
            m_wrap[k] = 1; m_ovf[k] = 1;
            if (!sat[k]) m_cnt[k] = 0;
          end else m_cnt[k] = m_cnt[k] + 1;
        end else if (en) begin
          if (m_cnt[k] == 0) begin
            m_wrap[k] = 1; m_unf[k] = 1;
            if (!sat[k]) m_cnt[k] = top;
          end else m_cnt[k] = m_cnt[k] - 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; en = 0; up = 0; load = 0; load_gray = '0; clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_g[k] !== 4'd0 || out_b[k] !== 4'd0 || ovf[k] !== 1'b0 || unf[k] !== 1'b0 || wrp[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset[%0d]: gray=%h bin=%h ovf=%b unf=%b wrap=%b, required all 0",
                 k, out_g[k], out_b[k], ovf[k], unf[k], wrp[k]);
      end
    end
  endtask

  task automatic test_up_wrap_w3();
    int exp_seq[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
    int wraps = 0;
    test_reset();
    en = 1; up = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (wrp[0] === 1'b1) wraps++;
      n_cmp++;
      if (g3 !== 3'(exp_seq[i])) begin
        n_err++;
        $display("FAIL up_seq_w3 step %0d: gray=%b required %b", i, g3, 3'(exp_seq[i]));
      end
      n_cmp++;
      if (ovf[0] !== (i == 7)) begin
        n_err++;
        $display("FAIL up_ovf_w3 step %0d: ovf=%b required %b", i, ovf[0], (i == 7));
      end
    end
    en = 0;
    step();
    n_cmp++;
    if (wraps != 1 || wrp[0] !== 1'b0 || ovf[0] !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_once_w3: pulses=%0d wrap=%b ovf=%b, required 1 pulse, wrap 0, ovf 1",
               wraps, wrp[0], ovf[0]);
    end
  endtask

  task automatic test_load_underflow_w4();
    test_reset();
    load = 1; load_gray = 4'b0000;
    step();
    load = 0; en = 1; up = 0;
    step();
    en = 0;
    n_cmp++;
    if (b4w !== 4'd15 || g4w !== 4'b1000 || unf[1] !== 1'b1 || ovf[1] !== 1'b0 || wrp[1] !== 1'b1) begin
      n_err++;
      $display("FAIL underflow_w4: bin=%0d gray=%b unf=%b ovf=%b wrap=%b, required 15 1000 1 0 1",
               b4w, g4w, unf[1], ovf[1], wrp[1]);
    end
  endtask

  task automatic test_saturate_and_clear();
    test_reset();
    load = 1; load_gray = 4'b1000;
    step();
    load = 0; en = 1; up = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (b4s !== 4'd15 || ovf[2] !== 1'b1 || wrp[2] !== 1'b1) begin
        n_err++;
        $display("FAIL saturate_hold step %0d: bin=%0d ovf=%b wrap=%b, required 15 1 1",
                 i, b4s, ovf[2], wrp[2]);
      end
    end
    en = 0; clr = 1;
    step();
    n_cmp++;
    if (ovf[2] !== 1'b0 || b4s !== 4'd15 || wrp[2] !== 1'b0) begin
      n_err++;
      $display("FAIL clr_flags: ovf=%b bin=%0d wrap=%b, required 0 15 0", ovf[2], b4s, wrp[2]);
    end
    en = 1; up = 1; clr = 1;
    step();
    en = 0; clr = 0;
    n_cmp++;
    if (ovf[2] !== 1'b1) begin
      n_err++;
      $display("FAIL set_beats_clr: ovf=%b required 1", ovf[2]);
    end
  endtask

  task automatic test_load_priority_and_reset();
    test_reset();
    load = 1; load_gray = 4'b0110; en = 1; up = 1;
    step();
    n_cmp++;
    if (b3 !== 3'd4) begin
      n_err++;
      $display("FAIL load_over_en: bin=%0d required 4", b3);
    end
    load = 0;
    step();
    n_cmp++;
    if (b3 !== 3'd5 || g3 !== 3'b111) begin
      n_err++;
      $display("FAIL step_after_load: bin=%0d gray=%b required 5 111", b3, g3);
    end
    reset = 1; en = 1; load = 1; load_gray = 4'b0101;
    step();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_g[k] !== 4'd0 || out_b[k] !== 4'd0 || ovf[k] !== 1'b0 || unf[k] !== 1'b0 || wrp[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid[%0d]: gray=%h bin=%h ovf=%b unf=%b wrap=%b, required all 0",
                 k, out_g[k], out_b[k], ovf[k], unf[k], wrp[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 99) < 2);
      load      = ($urandom_range(0, 99) < 8);
      clr       = ($urandom_range(0, 99) < 10);
      en        = ($urandom_range(0, 99) < 75);
      // Long runs in one direction reach the boundaries regularly.
      if ($urandom_range(0, 99) < 10) up = ~up;
      load_gray = 4'($urandom_range(0, 15));
      step();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (out_b[k] !== 4'(m_cnt[k]) || out_g[k] !== 4'(to_gray(m_cnt[k])) ||
            ovf[k] !== m_ovf[k] || unf[k] !== m_unf[k] || wrp[k] !== m_wrap[k]) begin
          n_err++;
          $display("FAIL random[%0d] cycle %0d: bin=%0d gray=%h ovf=%b unf=%b wrap=%b, required %0d %h %b %b %b",
                   k, c, out_b[k], out_g[k], ovf[k], unf[k], wrp[k],
                   m_cnt[k], to_gray(m_cnt[k]), m_ovf[k], m_unf[k], m_wrap[k]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_up_wrap_w3();
    test_load_underflow_w4();
    test_saturate_and_clear();
    test_load_priority_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
